// File: rtl/kapt0n_accum_if.sv
// rtl/kapt0n_accum_if.sv - operation/result handshake bundle for kapt0n_accum
interface kapt0n_accum_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [CW-1:0]    in_ch;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_flag;
    logic [CW-1:0]    out_ch;

    modport master (
        output in_valid, in_mode, in_ch, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_flag, out_ch
    );

    modport slave (
        input  in_valid, in_mode, in_ch, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_flag, out_ch
    );
endinterface

// File: rtl/kapt0n_accum.sv
// rtl/kapt0n_accum.sv - multi-channel add/sub/accumulate unit with a one-deep result register
module kapt0n_accum #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    kapt0n_accum_if.slave bus
);
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_ACC = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic [WIDTH-1:0] acc [CHANNELS];
    logic [WIDTH-1:0] acc_sel;
    logic [CW-1:0]    ch_idx;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] res_data;
    logic             res_flag;
    logic             accept;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_flag_q;
    logic [CW-1:0]    out_ch_q;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.out_ch    = out_ch_q;

    assign accept = bus.in_valid && bus.in_ready;

    // A single accumulator has no select bits; pin the index so out_ch reads 0.
    assign ch_idx = (CHANNELS == 1) ? '0 : bus.in_ch;

    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_idx == CW'(i)) begin
                acc_sel = acc[i];
            end
        end
    end

    always_comb begin
        r        = '0;
        res_data = '0;
        res_flag = 1'b0;
        case (bus.in_mode)
            MODE_ADD: begin
                r        = {1'b0, bus.in_a} + {1'b0, bus.in_b};
                res_flag = r[WIDTH];
                res_data = (SATURATE != 0 && res_flag) ? '1 : r[WIDTH-1:0];
            end
            MODE_ACC: begin
                r        = {1'b0, acc_sel} + {1'b0, bus.in_a};
                res_flag = r[WIDTH];
                res_data = (SATURATE != 0 && res_flag) ? '1 : r[WIDTH-1:0];
            end
            MODE_SUB: begin
                r        = {1'b0, bus.in_a} - {1'b0, bus.in_b};
                res_flag = (bus.in_a < bus.in_b);
                res_data = (SATURATE != 0 && res_flag) ? '0 : r[WIDTH-1:0];
            end
            default: begin
                res_data = acc_sel;
                res_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flag_q  <= 1'b0;
            out_ch_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_data;
                out_flag_q  <= res_flag;
                out_ch_q    <= ch_idx;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Accumulators commit at acceptance so back-to-back ACCs chain without forwarding.
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept && ch_idx == CW'(i)) begin
                    if (bus.in_mode == MODE_ACC) begin
                        acc[i] <= res_data;
                    end else if (bus.in_mode == MODE_CLR) begin
                        acc[i] <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_kapt0n_accum.sv
// tb/tb_kapt0n_accum.sv - directed self-checking bench for kapt0n_accum
module tb_kapt0n_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    kapt0n_accum_if #(.WIDTH(8),  .CW(2)) i8  ();
    kapt0n_accum_if #(.WIDTH(8),  .CW(2)) is8 ();
    kapt0n_accum_if #(.WIDTH(16), .CW(1)) i16 ();

    kapt0n_accum #(.WIDTH(8),  .CHANNELS(4), .SATURATE(0)) dut_wrap (.clk(clk), .rst(rst), .bus(i8));
    kapt0n_accum #(.WIDTH(8),  .CHANNELS(4), .SATURATE(1)) dut_sat  (.clk(clk), .rst(rst), .bus(is8));
    kapt0n_accum #(.WIDTH(16), .CHANNELS(1), .SATURATE(0)) dut_w16  (.clk(clk), .rst(rst), .bus(i16));

    task automatic drive8(input logic [1:0] m, input logic [1:0] ch, input logic [7:0] a, input logic [7:0] b);
        i8.in_valid = 1'b1; i8.in_mode = m; i8.in_ch = ch; i8.in_a = a; i8.in_b = b;
    endtask

    task automatic drives(input logic [1:0] m, input logic [1:0] ch, input logic [7:0] a, input logic [7:0] b);
        is8.in_valid = 1'b1; is8.in_mode = m; is8.in_ch = ch; is8.in_a = a; is8.in_b = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({i8.out_valid, i8.out_flag, i8.out_data, i8.out_ch} !== 12'h0) begin
            failures++;
            $display("FAIL reset_out8 got v=%b f=%b d=%0d ch=%0d want all 0", i8.out_valid, i8.out_flag, i8.out_data, i8.out_ch);
        end
        checks++;
        if (i8.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b want 1", i8.in_ready);
        end
        checks++;
        if ({is8.out_valid, i16.out_valid, i16.out_data} !== 18'h0) begin
            failures++;
            $display("FAIL reset_others got sat_v=%b w16_v=%b w16_d=%0d want 0", is8.out_valid, i16.out_valid, i16.out_data);
        end
    endtask

    task automatic test_wrap;
        logic [1:0] md [3] = '{2'b00, 2'b10, 2'b00};
        logic [7:0] va [3] = '{8'd200, 8'd5, 8'd3};
        logic [7:0] vb [3] = '{8'd100, 8'd7, 8'd4};
        logic [7:0] ed [3] = '{8'd44, 8'd254, 8'd7};
        logic       ef [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive8(md[i], 2'd0, va[i], vb[i]);
            @(negedge clk);
            checks++;
            if ({i8.out_valid, i8.out_flag, i8.out_data} !== {1'b1, ef[i], ed[i]}) begin
                failures++;
                $display("FAIL wrap_%0d got v=%b f=%b d=%0d want v=1 f=%b d=%0d", i, i8.out_valid, i8.out_flag, i8.out_data, ef[i], ed[i]);
            end
        end
        i8.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (i8.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_drain got v=%b want 0", i8.out_valid);
        end
    endtask

    task automatic test_saturate;
        logic [1:0] md [5] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
        logic [7:0] va [5] = '{8'd200, 8'd5, 8'd250, 8'd250, 8'd0};
        logic [7:0] vb [5] = '{8'd100, 8'd7, 8'd0, 8'd0, 8'd0};
        logic [7:0] ed [5] = '{8'd255, 8'd0, 8'd250, 8'd255, 8'd255};
        logic       ef [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drives(md[i], 2'd0, va[i], vb[i]);
            @(negedge clk);
            checks++;
            if ({is8.out_valid, is8.out_flag, is8.out_data} !== {1'b1, ef[i], ed[i]}) begin
                failures++;
                $display("FAIL sat_%0d got v=%b f=%b d=%0d want v=1 f=%b d=%0d", i, is8.out_valid, is8.out_flag, is8.out_data, ef[i], ed[i]);
            end
        end
        is8.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_chain;
        logic [1:0] md [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
        logic [1:0] ch [7] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1};
        logic [7:0] va [7] = '{8'd10, 8'd20, 8'd5, 8'd1, 8'd0, 8'd0, 8'd0};
        logic [7:0] ed [7] = '{8'd10, 8'd30, 8'd5, 8'd31, 8'd31, 8'd5, 8'd0};
        for (int i = 0; i < 7; i++) begin
            drive8(md[i], ch[i], va[i], 8'hAA);
            @(negedge clk);
            checks++;
            if ({i8.out_valid, i8.out_flag, i8.out_data, i8.out_ch} !== {1'b1, 1'b0, ed[i], ch[i]}) begin
                failures++;
                $display("FAIL chain_%0d got v=%b f=%b d=%0d ch=%0d want v=1 f=0 d=%0d ch=%0d", i, i8.out_valid, i8.out_flag, i8.out_data, i8.out_ch, ed[i], ch[i]);
            end
        end
        i8.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        drive8(2'b01, 2'd0, 8'd1, 8'd0);
        @(negedge clk);
        checks++;
        if ({i8.out_valid, i8.out_data} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL bp_first got v=%b d=%0d want v=1 d=1", i8.out_valid, i8.out_data);
        end
        i8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({i8.in_ready, i8.out_valid, i8.out_data} !== {1'b0, 1'b1, 8'd1}) begin
                failures++;
                $display("FAIL bp_stall_%0d got rdy=%b v=%b d=%0d want rdy=0 v=1 d=1", i, i8.in_ready, i8.out_valid, i8.out_data);
            end
            @(negedge clk);
        end
        i8.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({i8.out_valid, i8.out_data} !== {1'b1, 8'(i + 2)}) begin
                failures++;
                $display("FAIL bp_release_%0d got v=%b d=%0d want v=1 d=%0d", i, i8.out_valid, i8.out_data, i + 2);
            end
        end
        drive8(2'b11, 2'd0, 8'd0, 8'd0);
        @(negedge clk);
        checks++;
        if ({i8.out_valid, i8.out_data} !== {1'b1, 8'd3}) begin
            failures++;
            $display("FAIL bp_clr got v=%b d=%0d want v=1 d=3", i8.out_valid, i8.out_data);
        end
        i8.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        drive8(2'b01, 2'd3, 8'd77, 8'd0);
        @(negedge clk);
        checks++;
        if ({i8.out_valid, i8.out_data, i8.out_ch} !== {1'b1, 8'd77, 2'd3}) begin
            failures++;
            $display("FAIL rm_acc got v=%b d=%0d ch=%0d want v=1 d=77 ch=3", i8.out_valid, i8.out_data, i8.out_ch);
        end
        i8.in_valid  = 1'b0;
        i8.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({i8.out_valid, i8.out_data} !== 9'h0) begin
            failures++;
            $display("FAIL rm_flush got v=%b d=%0d want v=0 d=0", i8.out_valid, i8.out_data);
        end
        rst = 1'b0;
        i8.out_ready = 1'b1;
        drive8(2'b01, 2'd3, 8'd1, 8'd0);
        @(negedge clk);
        checks++;
        if ({i8.out_valid, i8.out_data, i8.out_ch} !== {1'b1, 8'd1, 2'd3}) begin
            failures++;
            $display("FAIL rm_after got v=%b d=%0d ch=%0d want v=1 d=1 ch=3", i8.out_valid, i8.out_data, i8.out_ch);
        end
        i8.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_param;
        logic [1:0]  md [3] = '{2'b00, 2'b01, 2'b11};
        logic [15:0] va [3] = '{16'hFFFF, 16'd5, 16'd0};
        logic [15:0] ed [3] = '{16'd0, 16'd5, 16'd5};
        logic        ef [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            i16.in_valid = 1'b1; i16.in_mode = md[i]; i16.in_ch = 1'b0;
            i16.in_a = va[i]; i16.in_b = 16'd1;
            @(negedge clk);
            checks++;
            if ({i16.out_valid, i16.out_flag, i16.out_data, i16.out_ch} !== {1'b1, ef[i], ed[i], 1'b0}) begin
                failures++;
                $display("FAIL w16_%0d got v=%b f=%b d=%0d ch=%0d want v=1 f=%b d=%0d ch=0", i, i16.out_valid, i16.out_flag, i16.out_data, i16.out_ch, ef[i], ed[i]);
            end
        end
        i16.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        i8.in_valid = 1'b0;  i8.in_mode = '0;  i8.in_ch = '0;  i8.in_a = '0;  i8.in_b = '0;  i8.out_ready = 1'b1;
        is8.in_valid = 1'b0; is8.in_mode = '0; is8.in_ch = '0; is8.in_a = '0; is8.in_b = '0; is8.out_ready = 1'b1;
        i16.in_valid = 1'b0; i16.in_mode = '0; i16.in_ch = '0; i16.in_a = '0; i16.in_b = '0; i16.out_ready = 1'b1;
        test_reset();
        test_wrap();
        test_saturate();
        test_chain();
        test_backpressure();
        test_reset_mid();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
